// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Brief    : Shared types and constants for the seven-segment scan block:
//             scan FSM encoding, digit count, hex segment map and a
//             digit-select helper.
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  // Number of multiplexed digits on the shared display.
  localparam int NUM_DIGITS = 4;

  // Scan FSM: each digit slot starts dark (BLANK), then drives (DRIVE).
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Active-low one-hot digit select for a digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_sel_n(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] one_hot;
    one_hot      = '0;
    one_hot[idx] = 1'b1;
    return ~one_hot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg_hex_decode
//  Brief    : Combinational hex-to-seven-segment decoder. 4-bit value in,
//             active-high {g..a} segment pattern out. All 16 codes mapped.
//  Revision : 1.0  initial release
// ============================================================================
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the selected digit value.
  always_comb begin
    seg = SEG_HEX_0;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_HEX_0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : Round-robin scan scheduler for the shared 4-digit seven-segment
//             display. Stores a hex value and decimal point per digit, scans
//             digits with a dark gap at the start of every slot, supports
//             per-digit enable and a blinking edit cursor.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_BITS   = 16,
  parameter int BLANK_CYC  = 64,
  parameter int BLINK_BITS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [3:0] digit_en,
  input  logic [1:0] cursor,
  input  logic       blink_en,
  output logic [3:0] sel_n,
  output logic [7:0] seg_n,
  output logic       frame_tick
);

  // A zero-length blank would never return to BLANK and stall the scan;
  // a blank as long as the slot would never drive.
  generate
    if ((BLANK_CYC < 1) || (BLANK_CYC >= (2 ** DIV_BITS))) begin : g_blank_cyc_check
      $error("seg_scan_ctrl: BLANK_CYC must be in 1 .. 2**DIV_BITS-1");
    end
  endgenerate

  localparam logic [DIV_BITS-1:0] BLANK_LIM = DIV_BITS'(BLANK_CYC);

  // ---------------------------------------------------------------------
  // Scan timing stage: slot counter, FSM state, digit index, blink phase.
  // state_q/idx_q always describe the slot position held in cnt_q.
  // ---------------------------------------------------------------------
  logic [DIV_BITS-1:0]   cnt_q,   cnt_d;
  scan_state_e           state_q, state_d;
  logic [1:0]            idx_q,   idx_d;
  logic                  wrap_q,  wrap_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  slot_end;

  // Digit storage.
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0]      dp_q,    dp_d;

  // Pixel stage: what the selected digit should show on the next cycle.
  logic       pix_lit_q,  pix_lit_d;
  logic [3:0] pix_val_q,  pix_val_d;
  logic       pix_dp_q,   pix_dp_d;
  logic [1:0] pix_idx_q,  pix_idx_d;
  logic       pix_tick_q, pix_tick_d;

  // Pin registers.
  logic [3:0] sel_n_q, sel_n_d;
  logic [7:0] seg_n_q, seg_n_d;
  logic       frame_tick_q, frame_tick_d;

  logic [6:0] hex_seg;

  // Next slot position, FSM next state, and index/blink advance at slot end.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    state_d  = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
    slot_end = (state_q == ST_DRIVE) && (state_d == ST_BLANK);
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    blink_d  = blink_q;
    if (slot_end) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        // Blink phase changes at the frame boundary so a whole cursor
        // slot always sees one consistent phase.
        wrap_d  = 1'b1;
        blink_d = blink_q + 1'b1;
      end
    end
  end

  // Scan FSM state register and slot timing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      wrap_q  <= 1'b0;
      blink_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      blink_q <= blink_d;
    end
  end

  // Write port: update the addressed digit value and decimal point.
  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    if (wr_en) begin
      digit_d[wr_addr] = wr_data;
      dp_d[wr_addr]    = wr_dp;
    end
  end

  // Digit storage; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
      dp_q    <= '0;
    end else begin
      digit_q <= digit_d;
      dp_q    <= dp_d;
    end
  end

  // Select the current digit and decide whether it is lit. A disabled or
  // blinked-off digit still consumes its slot, keeping brightness constant.
  always_comb begin
    pix_lit_d  = (state_q == ST_DRIVE)
               && digit_en[idx_q]
               && !(blink_en && (cursor == idx_q) && blink_q[BLINK_BITS-1]);
    pix_val_d  = digit_q[idx_q];
    pix_dp_d   = dp_q[idx_q];
    pix_idx_d  = idx_q;
    pix_tick_d = wrap_q;
  end

  // Pixel stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_lit_q  <= 1'b0;
      pix_val_q  <= 4'h0;
      pix_dp_q   <= 1'b0;
      pix_idx_q  <= 2'd0;
      pix_tick_q <= 1'b0;
    end else begin
      pix_lit_q  <= pix_lit_d;
      pix_val_q  <= pix_val_d;
      pix_dp_q   <= pix_dp_d;
      pix_idx_q  <= pix_idx_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  seg_hex_decode u_hex_decode (
    .hex (pix_val_q),
    .seg (hex_seg)
  );

  // Build the active-low pin values; dark unless the pixel stage is lit.
  always_comb begin
    sel_n_d      = 4'hF;
    seg_n_d      = 8'hFF;
    frame_tick_d = pix_tick_q;
    if (pix_lit_q) begin
      sel_n_d = digit_sel_n(pix_idx_q);
      seg_n_d = ~{pix_dp_q, hex_seg};
    end
  end

  // Pin registers: no combinational path from any input to the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_n_q      <= 4'hF;
      seg_n_q      <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      sel_n_q      <= sel_n_d;
      seg_n_q      <= seg_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel_n      = sel_n_q;
  assign seg_n      = seg_n_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
